line_mem_ctrl: RTL

LINE_MEM_CTRL -- requirements
Module: line_mem_ctrl

---
 rtl/line_mem_ctrl_pkg.sv | 17 +
 rtl/line_mem_ctrl_word_ram.sv | 22 ++
 rtl/line_mem_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/line_mem_ctrl_pkg.sv
// Shared types and constants for the line memory controller.
// Holds the FSM state encoding and the line geometry.
package line_mem_ctrl_pkg;

    localparam int LINE_WIDTH     = 128;
    localparam int WORDS_PER_LINE = 4;
    localparam int WORD_WIDTH     = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_QUAL = 3'd1,
        ST_WAIT = 3'd2,
        ST_XFER = 3'd3,
        ST_RESP = 3'd4
    } state_t;

endpackage

// File: rtl/line_mem_ctrl_word_ram.sv
// Single-port 32-bit word RAM with 1-cycle synchronous read.
// Contents are never reset.
module word_ram #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/line_mem_ctrl.sv
// Line-granular memory controller: qualifies a cache request, waits,
// then moves a 4-word line to or from the backing word RAM.
module line_mem_ctrl
    import line_mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  mem_r,
    input  logic                  mem_w,
    input  logic [31:0]           mem_addr,
    input  logic [LINE_WIDTH-1:0] mem_w_data,
    output logic [LINE_WIDTH-1:0] mem_r_data,
    output logic                  mem_ready,
    output logic                  busy
);

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t state, state_nx;

    logic                                     op_w;
    logic [27:0]                              addr_q;
    logic [3:0]                               cnt;
    logic [2:0]                               beat;
    logic [WORDS_PER_LINE-1:0][WORD_WIDTH-1:0] wbuf;
    logic [WORDS_PER_LINE-1:0][WORD_WIDTH-1:0] rbuf;

    logic                  req;
    logic                  same;
    logic                  last_beat;
    logic [1:0]            rd_idx;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [31:0]           ram_wdata;
    logic [31:0]           ram_rdata;
    logic                  unused_ok;

    assign unused_ok = ^mem_addr[3:0];

    assign req       = mem_r | mem_w;
    assign same      = req && (mem_w == op_w) && (mem_addr[31:4] == addr_q);
    assign last_beat = op_w ? (beat == 3'd3) : (beat == 3'd4);
    assign rd_idx    = beat[1:0] - 2'd1;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (req) state_nx = ST_QUAL;
            ST_QUAL: begin
                if (!same) begin
                    state_nx = ST_IDLE;
                end else if (LATENCY == 0) begin
                    state_nx = ST_XFER;
                end else begin
                    state_nx = ST_WAIT;
                end
            end
            ST_WAIT: if (cnt == 4'd0) state_nx = ST_XFER;
            ST_XFER: if (last_beat) state_nx = ST_RESP;
            ST_RESP: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        mem_ready = (state == ST_RESP);
        busy      = (state != ST_IDLE);
        ram_we    = (state == ST_XFER) && op_w && !beat[2];
        ram_addr  = {addr_q[ADDR_WIDTH-3:0], beat[1:0]};
        ram_wdata = wbuf[beat[1:0]];
    end

    // Datapath: request capture, write buffer, counters, read line
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_w       <= 1'b0;
            addr_q     <= '0;
            cnt        <= '0;
            beat       <= '0;
            wbuf       <= '0;
            rbuf       <= '0;
            mem_r_data <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (req) begin
                        op_w   <= mem_w;
                        addr_q <= mem_addr[31:4];
                    end
                end
                ST_QUAL: begin
                    if (same) begin
                        wbuf <= mem_w_data;
                        cnt  <= LAT_M1;
                        beat <= '0;
                    end
                end
                ST_WAIT: cnt <= cnt - 4'd1;
                ST_XFER: begin
                    beat <= beat + 3'd1;
                    // RAM data trails the issued address by one beat
                    if (!op_w && beat != 3'd0) begin
                        rbuf[rd_idx] <= ram_rdata;
                    end
                    if (!op_w && beat == 3'd4) begin
                        mem_r_data <= {ram_rdata, rbuf[2], rbuf[1], rbuf[0]};
                    end
                end
                ST_RESP: beat <= '0;
                default: ;
            endcase
        end
    end

    word_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

endmodule
